alif_multi_channel_neuron: RTL and testbench
============================================

# alif_multi_channel_neuron

Parametrised adaptive leaky integrate-and-fire neuron with N_CH input channels and signed per-channel weights, so excitatory and inhibitory synapses share one neuron. Channel products are accumulated sequentially with one shared multiplier, then a single membrane update applies leak, clamping, adaptive threshold and a programmable refractory period. It sits between the parameter loader and the spike output/readout logic. It replaces the single-channel neuron wherever more than one input drives a neuron.

## Interface
- N_CH, 4: number of input channels (≥2)
- IN_W, 6: unsigned input width per channel
- W_W, 4: signed two's-complement weight width per channel
- V_BITS, 8: membrane and threshold width (unsigned)
- THR_UP, 4: threshold increment per spike
- THR_DN, 1: threshold decrement per leak update without spike
- ACC_W (derived, not overridable): IN_W+W_W+clog2(N_CH)+1, signed accumulator width

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  gates sample acceptance
- params_ready  in  1  gates sample acceptance
- sample_valid  in  1  request to process one input sample
- sample_ready  out  1  high only in IDLE
- chan_in  in  N_CH*IN_W  channel c at bits [c*IN_W +: IN_W]
- weights  in  N_CH*W_W  signed weight c at bits [c*W_W +: W_W]
- leak_rate  in  V_BITS  amount subtracted on leak updates
- threshold_min  in  V_BITS  adaptive threshold floor
- leak_cycles  in  4  leak on every (leak_cycles+1)-th integrated update
- refrac_period  in  4  samples discarded after a spike
- spike_out  out  1  one-cycle spike pulse
- v_mem_out  out  V_BITS  membrane potential
- threshold_out  out  V_BITS  current adaptive threshold
- refractory  out  1  high while refr_cnt != 0

## Operation
- FSM states:
  - IDLE: sample_ready=1. Accept when sample_valid && enable && params_ready.
    - If refr_cnt != 0: the sample is consumed and discarded, refr_cnt decrements, state stays IDLE, no leak-counter or threshold change.
    - Otherwise: latch chan_in and weights, clear acc and idx, go to ACCUM.
  - ACCUM: each cycle acc += $unsigned(chan[idx]) * $signed(w[idx]) and idx++. After idx = N_CH-1, go to UPDATE.
  - UPDATE: compute the new membrane value, spike logic and leak counter as below, then return to IDLE.
- Membrane update, evaluated in signed ACC_W+1 bits:
  - new_v = v_mem + acc.
  - If apply_leak (leak_cnt >= leak_cycles), subtract leak_rate.
  - Clamp to the range [0, 2^V_BITS-1].
- Spike, when new_v >= threshold:
  - spike_out=1 and v_mem=0.
  - refr_cnt=refrac_period.
  - threshold=min(threshold+THR_UP, thr_max), where thr_max=min(2*threshold_min, 2^V_BITS-1). Use V_BITS+1 bit arithmetic; no wrap.
- No spike:
  - v_mem=new_v.
  - If apply_leak, threshold=max(threshold-THR_DN, threshold_min). The subtraction must not underflow.
- Leak counter:
  - Updates only in UPDATE: 0 if apply_leak, else +1.
  - leak_cycles=0 means leak on every update.
- Gating and input changes:
  - sample_valid, enable and params_ready are ignored outside IDLE. An in-flight sample always completes.
  - chan_in and weights changes after acceptance have no effect.
  - threshold_min and leak_rate are read live. The threshold register is reloaded from threshold_min only by reset.
- refractory = (refr_cnt != 0).

## Timing
- Reset values, including reset asserted mid-ACCUM/UPDATE:
  - State IDLE, sample_ready=1.
  - spike_out=0, v_mem_out=0, refractory=0.
  - acc, idx, leak_cnt and refr_cnt all 0.
  - threshold_out=threshold_min as sampled at reset.
- Cycle timing for a sample accepted on edge E0:
  - ACCUM products are added on edges E1..E_N (N=N_CH).
  - UPDATE registers are written on edge E_{N+1}. From that edge, spike_out is high for exactly one cycle and v_mem_out/threshold_out show new values.
  - sample_ready is low from E0 to E_{N+1} and high after E_{N+1}.
- Throughput: the next acceptance can occur at E_{N+2} at the earliest, giving one sample per N_CH+2 cycles.
- Discarded refractory samples take one cycle. sample_ready stays high and spike_out stays 0.
- spike_out is 0 in every cycle other than the post-UPDATE cycle of a spiking sample.

## Test plan
- Reset: thr_min=20, reset for 2 cycles -> all outputs 0 except sample_ready=1 and threshold_out=20; same result when reset pulses during ACCUM.
- Integrate/spike: chan0=5, w0=3, others 0, leak_rate=0, thr_min=20, refrac_period=2 -> first sample gives v=15 and no spike. Second sample gives spike_out=1 exactly 5 cycles after accept, v=0, threshold=24, refractory=1. The next two samples are discarded (v stays 0) and refractory clears after the second.
- Inhibition/clamp: chan0=63 with w0=-8 (4'h8), chan1=63 with w1=7 -> acc=-63 and v clamps to 0. All four channels 63, w=7, thr_min=200 -> spike.
- Threshold saturation: thr_min=200, refrac_period=0, repeated spiking samples -> threshold steps 204, 208, … 252, then 255, then holds at 255.
- Leak: leak_cycles=2, leak_rate=3, chan0=1, w0=1, thr_min=50 at threshold 54 -> v goes 1, 2, 0 with leak on the 3rd update. Threshold reaches 53 on that update, and leak_cnt wraps to 0.
- Handshake: sample_valid held high through ACCUM/UPDATE -> extra requests are ignored and exactly one update happens per N_CH+2 cycles. enable=0 or params_ready=0 in IDLE -> no acceptance and no state change.

Source files
------------

// File: rtl/alif_multi_channel_neuron.sv
// Adaptive leaky integrate-and-fire neuron with N_CH signed-weight channels
// accumulated serially through one multiplier, then a single membrane update.
module alif_multi_channel_neuron #(
    parameter int N_CH   = 4,
    parameter int IN_W   = 6,
    parameter int W_W    = 4,
    parameter int V_BITS = 8,
    parameter int THR_UP = 4,
    parameter int THR_DN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   params_ready,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic [N_CH*IN_W-1:0]   chan_in,
    input  logic [N_CH*W_W-1:0]    weights,
    input  logic [V_BITS-1:0]      leak_rate,
    input  logic [V_BITS-1:0]      threshold_min,
    input  logic [3:0]             leak_cycles,
    input  logic [3:0]             refrac_period,
    output logic                   spike_out,
    output logic [V_BITS-1:0]      v_mem_out,
    output logic [V_BITS-1:0]      threshold_out,
    output logic                   refractory
);
    // state  | meaning
    // IDLE   | ready for a sample; refractory samples are discarded here
    // ACCUM  | one channel product added to acc per cycle
    // UPDATE | membrane, spike, threshold and leak counter written

    localparam int ACC_W = IN_W + W_W + $clog2(N_CH) + 1;
    localparam int IDX_W = $clog2(N_CH);
    localparam int S_W   = ACC_W + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [V_BITS:0]   V_MAX    = {1'b0, {V_BITS{1'b1}}};
    localparam logic [V_BITS:0]   THR_UP_X = (V_BITS + 1)'(THR_UP);
    localparam logic [V_BITS:0]   THR_DN_X = (V_BITS + 1)'(THR_DN);
    localparam logic [V_BITS-1:0] THR_DN_V = V_BITS'(THR_DN);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t                   state;
    logic [N_CH*IN_W-1:0]     chan_q;
    logic [N_CH*W_W-1:0]      w_q;
    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic [V_BITS-1:0]        v_mem;
    logic [V_BITS-1:0]        threshold;
    logic [3:0]               leak_cnt;
    logic [3:0]               refr_cnt;

    logic [IN_W-1:0]          cur_chan;
    logic signed [W_W-1:0]    cur_w;
    logic signed [ACC_W-1:0]  prod;

    assign cur_chan = chan_q[int'(idx)*IN_W +: IN_W];
    assign cur_w    = w_q[int'(idx)*W_W +: W_W];
    // channel value is unsigned, so it is zero-extended before the signed multiply
    assign prod = $signed({{(ACC_W-IN_W){1'b0}}, cur_chan})
                * $signed({{(ACC_W-W_W){cur_w[W_W-1]}}, cur_w});

    logic                     apply_leak;
    logic signed [S_W-1:0]    v_ext;
    logic signed [S_W-1:0]    acc_ext;
    logic signed [S_W-1:0]    leak_ext;
    logic signed [S_W-1:0]    sum;
    logic [V_BITS-1:0]        new_v;
    logic                     fire;
    logic [V_BITS:0]          tmin2;
    logic [V_BITS:0]          thr_max;
    logic [V_BITS:0]          thr_inc;
    logic [V_BITS:0]          thr_floor;
    logic [V_BITS-1:0]        thr_next_up;
    logic [V_BITS-1:0]        thr_next_dn;

    always_comb begin
        apply_leak = (leak_cnt >= leak_cycles);
        v_ext      = $signed({{(S_W-V_BITS){1'b0}}, v_mem});
        acc_ext    = $signed({acc[ACC_W-1], acc});
        leak_ext   = apply_leak ? $signed({{(S_W-V_BITS){1'b0}}, leak_rate}) : '0;
        sum        = v_ext + acc_ext - leak_ext;

        if (sum[S_W-1])
            new_v = '0;
        else if (sum[S_W-2:V_BITS] != '0)
            new_v = {V_BITS{1'b1}};
        else
            new_v = sum[V_BITS-1:0];

        fire = (new_v >= threshold);

        // ceiling is twice the floor, saturated to the membrane range
        tmin2       = {threshold_min, 1'b0};
        thr_max     = (tmin2 > V_MAX) ? V_MAX : tmin2;
        thr_inc     = {1'b0, threshold} + THR_UP_X;
        thr_next_up = (thr_inc > thr_max) ? thr_max[V_BITS-1:0] : thr_inc[V_BITS-1:0];

        thr_floor   = {1'b0, threshold_min} + THR_DN_X;
        thr_next_dn = ({1'b0, threshold} < thr_floor) ? threshold_min
                                                      : threshold - THR_DN_V;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
            spike_out    <= 1'b0;
            chan_q       <= '0;
            w_q          <= '0;
            acc          <= '0;
            idx          <= '0;
            v_mem        <= '0;
            threshold    <= threshold_min;
            leak_cnt     <= '0;
            refr_cnt     <= '0;
        end else begin
            spike_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid && enable && params_ready) begin
                        if (refr_cnt != '0) begin
                            refr_cnt <= refr_cnt - 4'd1;
                        end else begin
                            chan_q       <= chan_in;
                            w_q          <= weights;
                            acc          <= '0;
                            idx          <= '0;
                            state        <= ACCUM;
                            sample_ready <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    acc <= acc + prod;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= UPDATE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                UPDATE: begin
                    leak_cnt <= apply_leak ? 4'd0 : leak_cnt + 4'd1;
                    if (fire) begin
                        spike_out <= 1'b1;
                        v_mem     <= '0;
                        refr_cnt  <= refrac_period;
                        threshold <= thr_next_up;
                    end else begin
                        v_mem <= new_v;
                        if (apply_leak)
                            threshold <= thr_next_dn;
                    end
                    state        <= IDLE;
                    sample_ready <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    sample_ready <= 1'b1;
                end
            endcase
        end
    end

    assign v_mem_out     = v_mem;
    assign threshold_out = threshold;
    assign refractory    = (refr_cnt != '0);

endmodule

// File: tb/tb_alif_multi_channel_neuron.sv
// Directed bench for alif_multi_channel_neuron with hand-computed expectations.
module tb_alif_multi_channel_neuron;
    localparam int N_CH = 4;
    localparam int IN_W = 6;
    localparam int W_W  = 4;
    localparam int V_BITS = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 params_ready;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [N_CH*IN_W-1:0] chan_in;
    logic [N_CH*W_W-1:0]  weights;
    logic [V_BITS-1:0]    leak_rate;
    logic [V_BITS-1:0]    threshold_min;
    logic [3:0]           leak_cycles;
    logic [3:0]           refrac_period;
    logic                 spike_out;
    logic [V_BITS-1:0]    v_mem_out;
    logic [V_BITS-1:0]    threshold_out;
    logic                 refractory;

    int n_checks = 0;
    int n_fail   = 0;

    alif_multi_channel_neuron #(
        .N_CH(N_CH), .IN_W(IN_W), .W_W(W_W), .V_BITS(V_BITS), .THR_UP(4), .THR_DN(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .params_ready(params_ready),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .chan_in(chan_in), .weights(weights), .leak_rate(leak_rate),
        .threshold_min(threshold_min), .leak_cycles(leak_cycles),
        .refrac_period(refrac_period), .spike_out(spike_out), .v_mem_out(v_mem_out),
        .threshold_out(threshold_out), .refractory(refractory)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_ch();
        chan_in = '0;
        weights = '0;
    endtask

    task automatic set_ch(input int c, input logic [IN_W-1:0] v, input logic [W_W-1:0] w);
        chan_in[c*IN_W +: IN_W] = v;
        weights[c*W_W +: W_W]   = w;
    endtask

    // accept on E0, then step to E_{N+1} watching the busy window
    task automatic send();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            chk("ready_low_busy", sample_ready, 0);
            chk("spike_low_busy", spike_out, 0);
            tick();
        end
        chk("ready_low_update", sample_ready, 0);
        tick();
    endtask

    task automatic chk_all_reset(input string tag, input int thr);
        chk({tag, "_ready"}, sample_ready, 1);
        chk({tag, "_spike"}, spike_out, 0);
        chk({tag, "_v"}, v_mem_out, 0);
        chk({tag, "_refr"}, refractory, 0);
        chk({tag, "_thr"}, threshold_out, thr);
    endtask

    initial begin
        int exp_thr;
        reset = 1'b1; enable = 1'b1; params_ready = 1'b1; sample_valid = 1'b0;
        chan_in = '0; weights = '0; leak_rate = 8'd0; threshold_min = 8'd20;
        leak_cycles = 4'd15; refrac_period = 4'd2;

        // reset, then reset pulsed in the middle of ACCUM
        do_reset();
        chk_all_reset("rst", 20);
        set_ch(0, 6'd5, 4'd3);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        do_reset();
        chk_all_reset("rst_mid", 20);
        tick();
        tick();
        chk("rst_mid_idle_v", v_mem_out, 0);

        // integrate then spike, then two discarded refractory samples
        send();
        chk("int1_v", v_mem_out, 15);
        chk("int1_spike", spike_out, 0);
        chk("int1_thr", threshold_out, 20);
        chk("int1_ready", sample_ready, 1);
        send();
        chk("spk_spike", spike_out, 1);
        chk("spk_v", v_mem_out, 0);
        chk("spk_thr", threshold_out, 24);
        chk("spk_refr", refractory, 1);
        tick();
        chk("spk_pulse_one_cycle", spike_out, 0);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("disc1_ready", sample_ready, 1);
        chk("disc1_spike", spike_out, 0);
        chk("disc1_v", v_mem_out, 0);
        chk("disc1_refr", refractory, 1);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("disc2_ready", sample_ready, 1);
        chk("disc2_v", v_mem_out, 0);
        chk("disc2_refr", refractory, 0);
        send();
        chk("post_refr_v", v_mem_out, 15);
        chk("post_refr_thr", threshold_out, 24);

        // inhibition clamps at zero; full excitation clamps high and spikes
        threshold_min = 8'd200; refrac_period = 4'd0;
        do_reset();
        clear_ch();
        set_ch(0, 6'd63, 4'h8);
        set_ch(1, 6'd63, 4'd7);
        send();
        chk("inh_v", v_mem_out, 0);
        chk("inh_spike", spike_out, 0);
        chk("inh_thr", threshold_out, 200);
        for (int c = 0; c < N_CH; c++) set_ch(c, 6'd63, 4'd7);
        send();
        chk("exc_spike", spike_out, 1);
        chk("exc_v", v_mem_out, 0);
        chk("exc_thr", threshold_out, 204);
        chk("exc_refr", refractory, 0);

        // threshold climbs by 4 up to the 255 ceiling and holds
        exp_thr = 204;
        for (int i = 0; i < 15; i++) begin
            exp_thr = (exp_thr + 4 > 255) ? 255 : exp_thr + 4;
            send();
            chk("sat_spike", spike_out, 1);
            chk("sat_thr", threshold_out, exp_thr);
        end

        // threshold floor, then leak every third update
        threshold_min = 8'd50; leak_cycles = 4'd0; leak_rate = 8'd0;
        do_reset();
        clear_ch();
        send();
        chk("floor_thr", threshold_out, 50);
        chk("floor_v", v_mem_out, 0);
        leak_rate = 8'd3;
        set_ch(0, 6'd63, 4'd7);
        send();
        chk("lk_prime_spike", spike_out, 1);
        chk("lk_prime_thr", threshold_out, 54);
        leak_cycles = 4'd2;
        set_ch(0, 6'd1, 4'd1);
        send();
        chk("lk1_v", v_mem_out, 1);
        chk("lk1_thr", threshold_out, 54);
        send();
        chk("lk2_v", v_mem_out, 2);
        chk("lk2_thr", threshold_out, 54);
        send();
        chk("lk3_v", v_mem_out, 0);
        chk("lk3_thr", threshold_out, 53);
        chk("lk3_spike", spike_out, 0);
        send();
        chk("lk4_v", v_mem_out, 1);
        chk("lk4_thr", threshold_out, 53);

        // handshake gating
        threshold_min = 8'd20; leak_cycles = 4'd15; leak_rate = 8'd0;
        do_reset();
        clear_ch();
        set_ch(0, 6'd1, 4'd1);
        enable = 1'b0;
        sample_valid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("en0_ready", sample_ready, 1);
        chk("en0_v", v_mem_out, 0);
        enable = 1'b1;
        params_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pr0_ready", sample_ready, 1);
        chk("pr0_v", v_mem_out, 0);
        params_ready = 1'b1;
        tick();
        chk("held_e0_ready", sample_ready, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("held_e4_v", v_mem_out, 0);
        tick();
        chk("held_e5_v", v_mem_out, 1);
        chk("held_e5_ready", sample_ready, 1);
        tick();
        chk("held_e6_ready", sample_ready, 0);
        chk("held_e6_v", v_mem_out, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("held_e10_v", v_mem_out, 1);
        tick();
        chk("held_e11_v", v_mem_out, 2);
        chk("held_e11_ready", sample_ready, 1);
        sample_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("held_after_v", v_mem_out, 2);
        chk("held_after_ready", sample_ready, 1);

        // inputs changed after acceptance are ignored
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        set_ch(0, 6'd30, 4'd7);
        for (int i = 0; i < 5; i++) tick();
        chk("latch_v", v_mem_out, 3);
        chk("latch_spike", spike_out, 0);
        chk("latch_thr", threshold_out, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
